// File: rtl/memory_access_stage_if.sv
// -----------------------------------------------------------------------------
// memory_access_stage_if
//   Request/acknowledge data-memory port used by the MEM stage.
//   The master (the MEM stage) holds req/we/addr/be/wdata stable from the first
//   request cycle until the slave returns ack. rdata is valid in the ack cycle.
//
//   Signals
//     req    master -> slave  access request
//     we     master -> slave  1 = write, 0 = read
//     addr   master -> slave  word-aligned byte address
//     be     master -> slave  byte-lane enables (bit n = byte n of the word)
//     wdata  master -> slave  lane-replicated store data
//     ack    slave  -> master access complete
//     rdata  slave  -> master read word, valid while ack is high
// -----------------------------------------------------------------------------
interface memory_access_stage_if #(
  parameter int WORD = 32
);
  logic            req;
  logic            we;
  logic [WORD-1:0] addr;
  logic [3:0]      be;
  logic [WORD-1:0] wdata;
  logic            ack;
  logic [WORD-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage_pkg / memory_access_stage
//   MEM pipeline stage sitting directly after the EX/MEM register.
//   Decodes Thumb load/store opcodes, runs one req/ack access at a time on the
//   data-memory port with byte-lane enables, sign/zero-extends load data and
//   registers the MEM/WB outputs. While an access is outstanding stall_o holds
//   PC/IF/ID/EX and the EX/MEM register. The EX/MEM destination and ALU result
//   are exposed combinationally for forwarding into EX.
//
//   Parameters
//     WORD        datapath width (byte-lane logic assumes 32)
//     ADDR_WIDTH  register-file address width
//
//   Ports
//     clk_i, reset_i           clock (rising edge), async active-low reset
//     is_valid_i               EX/MEM entry valid
//     mem_write_en_i           store enable from EX/MEM
//     reg_file_write_en_i      register-file write enable
//     reg_file_data_source_i   write-back data: ALU result or memory data
//     opA_opB_i                [6:3] opA, [2:0] opB (Thumb encoding)
//     reg_dest_addr_i          destination register
//     alu_result_i             effective address / ALU result
//     reg_2_data_i             store data
//     dmem                     data-memory port (master side)
//     stall_o                  freeze upstream pipe
//     reg_write_en_MEM_o       forward: write enable of the EX/MEM entry
//     reg_dest_MEM_o           forward: destination of the EX/MEM entry
//     reg_data_MEM_o           forward: ALU result of the EX/MEM entry
//     is_valid_o               MEM/WB entry valid
//     reg_file_write_en_o      MEM/WB register-file write enable
//     reg_dest_addr_o          MEM/WB destination
//     reg_data_o               MEM/WB write-back data
//     align_fault_o            (MEM_ALIGN_FAULT_EN only) misaligned-access pulse
//
//   Build option
//     MEM_ALIGN_FAULT_EN  when defined, misaligned half/word accesses issue no
//                         request, pulse align_fault_o and retire as a bubble.
//                         When undefined, lanes simply follow the address bits.
// -----------------------------------------------------------------------------
package memory_access_stage_pkg;

  typedef enum logic {
    MEM_WRITE_NONE = 1'b0,
    MEM_WRITE_EN   = 1'b1
  } mem_write_signal;

  typedef enum logic {
    RF_WRITE_NONE = 1'b0,
    RF_WRITE_EN   = 1'b1
  } reg_file_write_sig;

  typedef enum logic {
    DATA_SRC_ALU = 1'b0,
    DATA_SRC_MEM = 1'b1
  } reg_file_data_source;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

  typedef struct packed {
    logic         is_mem;
    logic         is_load;
    logic         is_signed;
    access_size_t size;
  } mem_decode_t;

  // Thumb load/store decode. Register-offset forms (opA=0101) carry size, sign
  // and direction in opB; immediate/SP-relative forms carry size in opA and
  // direction in opB[2].
  function automatic mem_decode_t decode_op(input logic [6:0] op);
    mem_decode_t d;
    d.is_mem    = 1'b0;
    d.is_load   = 1'b0;
    d.is_signed = 1'b0;
    d.size      = SIZE_WORD;
    case (op[6:3])
      4'b0101: begin
        d.is_mem = 1'b1;
        case (op[2:0])
          3'b000: begin d.is_load = 1'b0; d.size = SIZE_WORD; end
          3'b001: begin d.is_load = 1'b0; d.size = SIZE_HALF; end
          3'b010: begin d.is_load = 1'b0; d.size = SIZE_BYTE; end
          3'b011: begin d.is_load = 1'b1; d.size = SIZE_BYTE; d.is_signed = 1'b1; end
          3'b100: begin d.is_load = 1'b1; d.size = SIZE_WORD; end
          3'b101: begin d.is_load = 1'b1; d.size = SIZE_HALF; end
          3'b110: begin d.is_load = 1'b1; d.size = SIZE_BYTE; end
          default: begin d.is_load = 1'b1; d.size = SIZE_HALF; d.is_signed = 1'b1; end
        endcase
      end
      4'b0110, 4'b1001: begin
        d.is_mem  = 1'b1;
        d.is_load = op[2];
        d.size    = SIZE_WORD;
      end
      4'b0111: begin
        d.is_mem  = 1'b1;
        d.is_load = op[2];
        d.size    = SIZE_BYTE;
      end
      4'b1000: begin
        d.is_mem  = 1'b1;
        d.is_load = op[2];
        d.size    = SIZE_HALF;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic                   is_valid_i,
  input  mem_write_signal        mem_write_en_i,
  input  reg_file_write_sig      reg_file_write_en_i,
  input  reg_file_data_source    reg_file_data_source_i,
  input  logic [6:0]             opA_opB_i,
  input  logic [ADDR_WIDTH-1:0]  reg_dest_addr_i,
  input  logic [WORD-1:0]        alu_result_i,
  input  logic [WORD-1:0]        reg_2_data_i,

  memory_access_stage_if.master  dmem,

  output logic                   stall_o,

  output reg_file_write_sig      reg_write_en_MEM_o,
  output logic [ADDR_WIDTH-1:0]  reg_dest_MEM_o,
  output logic [WORD-1:0]        reg_data_MEM_o,

  output logic                   is_valid_o,
  output reg_file_write_sig      reg_file_write_en_o,
  output logic [ADDR_WIDTH-1:0]  reg_dest_addr_o,
  output logic [WORD-1:0]        reg_data_o
`ifdef MEM_ALIGN_FAULT_EN
  ,
  output logic                   align_fault_o
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t state;

  // Decode of the entry currently in EX/MEM.
  mem_decode_t dec;
  logic        accept;
  logic        issue;
  logic        fault_access;

  // Registered memory-port drivers.
  logic            req_q;
  logic            we_q;
  logic [WORD-1:0] addr_out_q;
  logic [3:0]      be_q;
  logic [WORD-1:0] wdata_q;

  // Access context captured at issue, used when the ack returns.
  logic [WORD-1:0]       addr_q;
  access_size_t          size_q;
  logic                  signed_q;
  reg_file_data_source   src_q;
  reg_file_write_sig     rf_we_q;
  logic [ADDR_WIDTH-1:0] dest_q;

  logic [3:0]      be_next;
  logic [WORD-1:0] wdata_next;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [WORD-1:0] load_data;

  assign dec = decode_op(opA_opB_i);

  // A decoded store only goes to memory when EX/MEM also enables the write;
  // otherwise the entry retires like a non-memory op.
  assign accept = is_valid_i && dec.is_mem &&
                  (dec.is_load || (mem_write_en_i == MEM_WRITE_EN));

`ifdef MEM_ALIGN_FAULT_EN
  logic misaligned;
  assign misaligned   = ((dec.size == SIZE_HALF) && alu_result_i[0]) ||
                        ((dec.size == SIZE_WORD) && (alu_result_i[1:0] != 2'b00));
  assign issue        = accept && !misaligned;
  assign fault_access = accept && misaligned;
`else
  assign issue        = accept;
  assign fault_access = 1'b0;
`endif

  // Lane enables and replicated write data for the access being issued.
  // Half/word lanes ignore the low address bits they cannot represent.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    be_next    = 4'b1111;
    wdata_next = reg_2_data_i;
    case (dec.size)
      SIZE_BYTE: begin
        be_next    = 4'b0001 << alu_result_i[1:0];
        wdata_next = {4{reg_2_data_i[7:0]}};
      end
      SIZE_HALF: begin
        be_next    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{reg_2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction and extension of the returned read word.
  always_comb begin
    lane_byte = dmem.rdata[7:0];
    case (addr_q[1:0])
      2'd1:    lane_byte = dmem.rdata[15:8];
      2'd2:    lane_byte = dmem.rdata[23:16];
      2'd3:    lane_byte = dmem.rdata[31:24];
      default: ;
    endcase
    lane_half = addr_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (size_q)
      SIZE_BYTE: load_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_data = {{16{signed_q & lane_half[15]}}, lane_half};
      default:   load_data = dmem.rdata;
    endcase
  end

  // Stall is combinational so the upstream pipe freezes in the very cycle the
  // op is seen, and releases in the ack cycle. Forced low while in reset.
  always_comb begin
    stall_o = 1'b0;
    if (reset_i) begin
      stall_o = (state == ST_IDLE) ? issue : !dmem.ack;
    end
  end

  // Forwarding taps straight off EX/MEM; held at zero during reset so EX never
  // picks up a bypass from an entry the pipe is about to discard.
  assign reg_write_en_MEM_o = (reset_i && is_valid_i) ? reg_file_write_en_i : RF_WRITE_NONE;
  assign reg_dest_MEM_o     = reset_i ? reg_dest_addr_i : '0;
  assign reg_data_MEM_o     = reset_i ? alu_result_i    : '0;

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_out_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state               <= ST_IDLE;
      req_q               <= 1'b0;
      we_q                <= 1'b0;
      addr_out_q          <= '0;
      be_q                <= '0;
      wdata_q             <= '0;
      addr_q              <= '0;
      size_q              <= SIZE_WORD;
      signed_q            <= 1'b0;
      src_q               <= DATA_SRC_ALU;
      rf_we_q             <= RF_WRITE_NONE;
      dest_q              <= '0;
      is_valid_o          <= 1'b0;
      reg_file_write_en_o <= RF_WRITE_NONE;
      reg_dest_addr_o     <= '0;
      reg_data_o          <= '0;
`ifdef MEM_ALIGN_FAULT_EN
      align_fault_o       <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_FAULT_EN
      align_fault_o <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state      <= ST_REQ;
            req_q      <= 1'b1;
            we_q       <= !dec.is_load;
            addr_out_q <= {alu_result_i[WORD-1:2], 2'b00};
            be_q       <= be_next;
            wdata_q    <= wdata_next;
            addr_q     <= alu_result_i;
            size_q     <= dec.size;
            signed_q   <= dec.is_signed;
            src_q      <= reg_file_data_source_i;
            rf_we_q    <= reg_file_write_en_i;
            dest_q     <= reg_dest_addr_i;
            // Stalled: the entry stays in EX/MEM, so WB gets a bubble.
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= RF_WRITE_NONE;
          end else if (fault_access) begin
`ifdef MEM_ALIGN_FAULT_EN
            align_fault_o <= 1'b1;
`endif
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= RF_WRITE_NONE;
          end else begin
            // Non-memory op or invalid entry: one-cycle pass-through.
            is_valid_o          <= is_valid_i;
            reg_file_write_en_o <= is_valid_i ? reg_file_write_en_i : RF_WRITE_NONE;
            reg_dest_addr_o     <= reg_dest_addr_i;
            reg_data_o          <= alu_result_i;
          end
        end

        ST_REQ: begin
          if (dmem.ack) begin
            state               <= ST_IDLE;
            req_q               <= 1'b0;
            is_valid_o          <= 1'b1;
            reg_file_write_en_o <= rf_we_q;
            reg_dest_addr_o     <= dest_q;
            reg_data_o          <= (src_q == DATA_SRC_MEM) ? load_data : addr_q;
          end else begin
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= RF_WRITE_NONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
